// File: rtl/button_pulse_gen.sv
// button_pulse_gen: synchronized, debounced SET/UP/DOWN buttons to one-cycle strobes.
// Define BTN_AUTOREPEAT_EN to enable UP/DOWN auto-repeat; otherwise every channel pulses once per press.
module button_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 100
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set,
  input  logic btn_up,
  input  logic btn_down,
  output logic pulsed_set,
  output logic pulsed_up,
  output logic pulsed_down,
  output logic held_any
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // channel bit 0 = SET, 1 = UP, 2 = DOWN
  logic [2:0] r_s1, r_s2, r_d, r_pulse;
  logic [2:0] w_diff, w_hit, w_nd, w_rise, w_pulse;
  logic [DW-1:0] r_cnt [3];
  logic w_conf;
  always_comb begin
    w_diff = r_s2 ^ r_d;
    w_hit = '0;
    for (int k = 0; k < 3; k++)
      w_hit[k] = w_diff[k] && r_cnt[k] == DW'(DEBOUNCE_CYCLES - 1);
    w_nd = r_d ^ w_hit;
    w_rise = w_hit & ~r_d;
    w_conf = w_nd[1] & w_nd[2];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_d <= '0;
      r_pulse <= '0;
      for (int k = 0; k < 3; k++)
        r_cnt[k] <= '0;
    end else begin
      r_s1 <= {btn_down, btn_up, btn_set};
      r_s2 <= r_s1;
      r_d <= w_nd;
      r_pulse <= w_pulse;
      for (int k = 0; k < 3; k++)
        r_cnt[k] <= (w_diff[k] && !w_hit[k]) ? r_cnt[k] + 1'b1 : '0;
    end
  end
`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {IDLE, ARMED, REPEAT} state_t;
  localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1;
  localparam logic [RW-1:0] L_DELAY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] L_PERIOD = RW'(REPEAT_PERIOD);
  // index 0 = UP, 1 = DOWN
  state_t r_st [2];
  logic [RW-1:0] r_tmr [2];
  logic [1:0] w_rep;
  always_comb begin
    w_rep = '0;
    for (int k = 0; k < 2; k++)
      w_rep[k] = r_st[k] != IDLE && r_d[k+1] && w_nd[k+1] && !w_conf &&
                 r_tmr[k] + 1'b1 == (r_st[k] == ARMED ? L_DELAY : L_PERIOD);
    w_pulse = {(w_rise[2:1] | w_rep) & ~{2{w_conf}}, w_rise[0]};
  end
  // a falling level wins over a due repeat, so release never emits a strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        r_st[k] <= IDLE;
        r_tmr[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!w_nd[k+1]) begin
          r_st[k] <= IDLE;
          r_tmr[k] <= '0;
        end else if (w_rise[k+1] || w_rep[k]) begin
          r_st[k] <= w_rise[k+1] ? ARMED : REPEAT;
          r_tmr[k] <= '0;
        end else if (!w_conf && r_tmr[k] != '1)
          r_tmr[k] <= r_tmr[k] + 1'b1;
      end
    end
  end
`else
  always_comb w_pulse = {w_rise[2:1] & ~{2{w_conf}}, w_rise[0]};
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_repeat_cfg_unused
  end
`endif
  assign {pulsed_down, pulsed_up, pulsed_set} = r_pulse;
  assign held_any = |r_d;
endmodule

// File: doc/button_pulse_gen.md
BUTTON_PULSE_GEN -- requirements
Module: button_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20, meaning: consecutive stable synchronized samples required to accept a level change (range 1 to 2^20-1).
REQ-002 Parameter REPEAT_DELAY, default 500, meaning: held-key cycles from first pulse to first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 100, meaning: cycles between subsequent auto-repeat pulses.
REQ-004 Port clk, input, 1, meaning: the single system clock; all state on rising edge.
REQ-005 Port reset, input, 1, meaning: asynchronous, active-low reset.
REQ-006 Port btn_set, input, 1, meaning: raw asynchronous SET push-button, active-high.
REQ-007 Port btn_up, input, 1, meaning: raw asynchronous UP push-button, active-high.
REQ-008 Port btn_down, input, 1, meaning: raw asynchronous DOWN push-button, active-high.
REQ-009 Port pulsed_set, output, 1, meaning: one-cycle SET strobe to the clock setter.
REQ-010 Port pulsed_up, output, 1, meaning: one-cycle UP strobe.
REQ-011 Port pulsed_down, output, 1, meaning: one-cycle DOWN strobe.
REQ-012 Port held_any, output, 1, meaning: high while any debounced button level is high.

Function
REQ-013 Each raw input SHALL pass through a two-flop synchronizer before any other logic.
REQ-014 Each channel SHALL keep a debounced level d and a counter cleared whenever the synchronized sample equals d.
- Counter increments each cycle the sample differs from d.
- d toggles on the edge where the counter would reach DEBOUNCE_CYCLES; the counter then clears.
REQ-015 A raw glitch shorter than DEBOUNCE_CYCLES cycles SHALL produce no d change and no pulse.
REQ-016 Each strobe SHALL be registered and asserted for exactly one cycle on the edge where d rises; a d fall SHALL produce no pulse.
REQ-017 Latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges from the first edge sampling raw high to pulse assertion, with raw held steady.
REQ-018 Up and down channels SHALL each run FSM IDLE -> ARMED -> REPEAT.
- IDLE -> ARMED on d rise (pulse issued).
- ARMED -> REPEAT after REPEAT_DELAY cycles with d high (pulse issued).
- REPEAT issues a pulse every REPEAT_PERIOD cycles while d high.
- Any state -> IDLE on d fall (no pulse).
REQ-019 The SET channel SHALL never auto-repeat; it stays ARMED until d falls.
REQ-020 If debounced up and down are both high in a cycle, pulsed_up and pulsed_down SHALL both be 0 that cycle, and both repeat timers SHALL hold.
REQ-021 pulsed_set SHALL be independent of up/down activity.
REQ-022 Repeat counters SHALL saturate, never wrap; width SHALL be clog2 of the maximum parameter plus 1.
REQ-023 held_any SHALL be the combinational OR of the three registered d levels.

Reset
REQ-024 While reset is low, all synchronizer flops, d levels, counters and FSMs SHALL be 0/IDLE; all outputs SHALL be 0 asynchronously.
REQ-025 Reset assertion mid-debounce or mid-repeat SHALL abort without issuing a pulse.
REQ-026 A button held through reset release SHALL be debounced afresh and SHALL pulse once per REQ-017 timing.

Configuration
REQ-027 Macro BTN_AUTOREPEAT_EN controls auto-repeat.
- Defined: REQ-018 behaviour applies to up/down.
- Undefined: up/down behave like SET (one pulse per press); REPEAT_DELAY/REPEAT_PERIOD are ignored and repeat counters are not synthesized.

Verification
REQ-028 Press: btn_up high for 200 cycles, DEBOUNCE_CYCLES=4 -> pulsed_up is 1 only at edge 6; with macro off, no further pulses.
REQ-029 Glitch: btn_set high for 3 cycles, DEBOUNCE_CYCLES=4 -> no pulsed_set, held_any stays 0.
REQ-030 Auto-repeat (macro on): DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5, btn_down held 40 cycles -> pulses at edges 6, 16, 21, 26, 31, 36, 41 (41 only if d still high), none after d falls.
REQ-031 Conflict: btn_up and btn_down rise together and are held -> no up/down pulses; btn_set pressed meanwhile -> one pulsed_set.
REQ-032 Reset: btn_up held, reset pulled low at cycle 8 of repeat wait -> outputs 0 immediately; after release, one pulse at DEBOUNCE_CYCLES+2 edges.
REQ-033 Bounce: btn_set toggles every 2 cycles for 20 cycles then stays high -> exactly one pulsed_set, DEBOUNCE_CYCLES+2 edges after the final rise.
